// File: rtl/led_pwm_pkg.sv
// Shared types and derived-constant helpers for the multi-channel LED PWM driver.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  function automatic int unsigned calc_blink_max(input int unsigned clk_freq,
                                                 input int unsigned blink_freq);
    return clk_freq / blink_freq / 32'd2 - 32'd1;
  endfunction

  // The ramp divider never drops below one cycle per step.
  function automatic int unsigned calc_ramp_max(input int unsigned clk_freq,
                                                input int unsigned blink_freq,
                                                input int unsigned pwm_bits);
    int unsigned div_v;
    div_v = clk_freq / (blink_freq * 32'd2 * ((32'd1 << pwm_bits) - 32'd1));
    if (div_v < 32'd1) begin
      div_v = 32'd1;
    end else begin
      div_v = div_v;
    end
    return div_v - 32'd1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 32'd0) ? $clog2(max_val + 32'd1) : 32'd1;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Configuration write bus from board-control logic into the LED PWM driver.
interface led_pwm_ctrl_if #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_BITS = 8
);
  localparam int unsigned CH_W = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1;

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [1:0]          wr_mode;
  logic [PWM_BITS-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_mode, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_mode, input  wr_duty);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, effective-duty select, PWM compare
// and the polarity-corrected output flop.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_stb,
  input  led_mode_t           wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wrap,
  input  logic                blink_phase,
  input  logic [PWM_BITS-1:0] ramp,
  input  logic                active_low,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};

  led_mode_t           shadow_mode_r;
  logic [PWM_BITS-1:0] shadow_duty_r;
  led_mode_t           act_mode_r;
  logic [PWM_BITS-1:0] act_duty_r;
  logic [PWM_BITS-1:0] eff_duty_s;
  logic                lit_s;
  logic                led_r;

  // Shadow register captures every accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mode_r <= LED_OFF;
      shadow_duty_r <= DUTY_ZERO;
    end else if (wr_stb) begin
      shadow_mode_r <= wr_mode;
      shadow_duty_r <= wr_duty;
    end else begin
      shadow_mode_r <= shadow_mode_r;
      shadow_duty_r <= shadow_duty_r;
    end
  end

  // Active register updates only at the period boundary; a write landing on
  // that same edge bypasses the shadow so it is not delayed a whole period.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode_r <= LED_OFF;
      act_duty_r <= DUTY_ZERO;
    end else if (wrap) begin
      if (wr_stb) begin
        act_mode_r <= wr_mode;
        act_duty_r <= wr_duty;
      end else begin
        act_mode_r <= shadow_mode_r;
        act_duty_r <= shadow_duty_r;
      end
    end else begin
      act_mode_r <= act_mode_r;
      act_duty_r <= act_duty_r;
    end
  end

  // Effective duty per mode, then the PWM compare.
  always_comb begin
    eff_duty_s = DUTY_ZERO;
    case (act_mode_r)
      LED_OFF:     eff_duty_s = DUTY_ZERO;
      LED_ON:      eff_duty_s = act_duty_r;
      LED_BLINK:   eff_duty_s = blink_phase ? act_duty_r : DUTY_ZERO;
      LED_BREATHE: eff_duty_s = ramp;
      default:     eff_duty_s = DUTY_ZERO;
    endcase
    lit_s = (eff_duty_s == DUTY_FULL) || (pwm_cnt < eff_duty_s);
  end

  // Registered pin with polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= active_low;
    end else begin
      led_r <= lit_s ^ active_low;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: shared PWM counter, blink timebase and breathe ramp
// feeding NUM_CH independently configured channels.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int unsigned          CLK_FREQ   = 20000000,
  parameter int unsigned          BLINK_FREQ = 1,
  parameter int unsigned          NUM_CH     = 3,
  parameter int unsigned          PWM_BITS   = 8,
  parameter logic [NUM_CH-1:0]    ACTIVE_LOW = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  led_pwm_ctrl_if.slave     bus,
  output logic [NUM_CH-1:0] led,
  output logic              blink_phase
);

  localparam int unsigned CH_W      = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1;
  localparam int unsigned BLINK_MAX = calc_blink_max(CLK_FREQ, BLINK_FREQ);
  localparam int unsigned RAMP_MAX  = calc_ramp_max(CLK_FREQ, BLINK_FREQ, PWM_BITS);
  localparam int unsigned BLINK_W   = cnt_width(BLINK_MAX);
  localparam int unsigned RAMP_W    = cnt_width(RAMP_MAX);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1'b1);
  localparam logic [BLINK_W-1:0]  BLINK_END = BLINK_W'(BLINK_MAX);
  localparam logic [BLINK_W-1:0]  BLINK_ONE = BLINK_W'(1'b1);
  localparam logic [RAMP_W-1:0]   RAMP_END  = RAMP_W'(RAMP_MAX);
  localparam logic [RAMP_W-1:0]   RAMP_ONE  = RAMP_W'(1'b1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [BLINK_W-1:0]  blink_cnt_r;
  logic                blink_phase_r;
  logic [RAMP_W-1:0]   ramp_div_r;
  logic [PWM_BITS-1:0] ramp_r;
  logic                ramp_up_r;
  logic                wrap_s;
  logic                ramp_step_s;
  logic [PWM_BITS-1:0] ramp_next_s;
  logic [NUM_CH-1:0]   wr_sel_s;

  assign wrap_s = (pwm_cnt_r == DUTY_FULL);

  // Free-running PWM period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= DUTY_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
    end
  end

  // Blink half-period timebase.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_END) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLINK_ONE;
      blink_phase_r <= blink_phase_r;
    end
  end

  // Next breathe ramp value in the current direction.
  always_comb begin
    ramp_step_s = (ramp_div_r == RAMP_END);
    if (ramp_up_r) begin
      ramp_next_s = ramp_r + PWM_ONE;
    end else begin
      ramp_next_s = ramp_r - PWM_ONE;
    end
  end

  // Shared triangle ramp; direction flips on reaching either end value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_div_r <= {RAMP_W{1'b0}};
      ramp_r     <= DUTY_ZERO;
      ramp_up_r  <= 1'b1;
    end else if (ramp_step_s) begin
      ramp_div_r <= {RAMP_W{1'b0}};
      ramp_r     <= ramp_next_s;
      if (ramp_next_s == DUTY_FULL) begin
        ramp_up_r <= 1'b0;
      end else if (ramp_next_s == DUTY_ZERO) begin
        ramp_up_r <= 1'b1;
      end else begin
        ramp_up_r <= ramp_up_r;
      end
    end else begin
      ramp_div_r <= ramp_div_r + RAMP_ONE;
      ramp_r     <= ramp_r;
      ramp_up_r  <= ramp_up_r;
    end
  end

  // Channel select; out-of-range channel numbers match nothing.
  always_comb begin
    wr_sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_stb      (wr_sel_s[g]),
      .wr_mode     (led_mode_t'(bus.wr_mode)),
      .wr_duty     (bus.wr_duty),
      .pwm_cnt     (pwm_cnt_r),
      .wrap        (wrap_s),
      .blink_phase (blink_phase_r),
      .ramp        (ramp_r),
      .active_low  (ACTIVE_LOW[g]),
      .led         (led[g])
    );
  end

  assign blink_phase = blink_phase_r;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: a cycle-count based reference model
// queues expected pin values, a negedge monitor compares them against the DUT.
module tb_led_pwm_ctrl;

  localparam int unsigned CLK_FREQ   = 3000;
  localparam int unsigned BLINK_FREQ = 100;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned PWM_BITS   = 4;
  localparam logic [2:0]  AL         = 3'b011;

  localparam int FULL      = 15;
  localparam int PERIOD    = 16;
  localparam int BLINK_MAX = int'(CLK_FREQ / BLINK_FREQ / 2) - 1;
  localparam int RAMP_RAW  = int'(CLK_FREQ / (BLINK_FREQ * 2 * 15));
  localparam int RAMP_MAX  = ((RAMP_RAW > 1) ? RAMP_RAW : 1) - 1;

  logic       clk;
  logic       rst;
  logic [2:0] led;
  logic       blink_phase;

  led_pwm_ctrl_if #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS)) bus ();

  led_pwm_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .BLINK_FREQ (BLINK_FREQ),
    .NUM_CH     (NUM_CH),
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .led         (led),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  // Reference model state: edges since reset plus per-channel configuration.
  int         m_k = 0;
  int         sh_mode [3];
  int         sh_duty [3];
  int         ac_mode [3];
  int         ac_duty [3];
  logic [3:0] exp_q [$];

  function automatic int tri_wave(input int steps);
    int p;
    p = steps % (2 * FULL);
    return (p <= FULL) ? p : (2 * FULL - p);
  endfunction

  always @(posedge clk) begin
    int         pwm;
    int         ph;
    int         rp;
    int         eff;
    logic [2:0] lit_v;
    if (rst) begin
      m_k = 0;
      for (int c = 0; c < 3; c++) begin
        sh_mode[c] = 0; sh_duty[c] = 0; ac_mode[c] = 0; ac_duty[c] = 0;
      end
      exp_q.push_back({1'b0, AL});
    end else begin
      pwm = m_k % PERIOD;
      ph  = (m_k / (BLINK_MAX + 1)) % 2;
      rp  = tri_wave(m_k / (RAMP_MAX + 1));
      for (int c = 0; c < 3; c++) begin
        case (ac_mode[c])
          0:       eff = 0;
          1:       eff = ac_duty[c];
          2:       eff = (ph == 1) ? ac_duty[c] : 0;
          default: eff = rp;
        endcase
        lit_v[c] = (eff == FULL) || (pwm < eff);
      end
      if (bus.wr_en && (int'(bus.wr_ch) < 3)) begin
        sh_mode[bus.wr_ch] = int'(bus.wr_mode);
        sh_duty[bus.wr_ch] = int'(bus.wr_duty);
      end
      if (pwm == FULL) begin
        for (int c = 0; c < 3; c++) begin
          ac_mode[c] = sh_mode[c];
          ac_duty[c] = sh_duty[c];
        end
      end
      m_k = m_k + 1;
      exp_q.push_back({((m_k / (BLINK_MAX + 1)) % 2 == 1), lit_v ^ AL});
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_pops++;
      checks++;
      if (led !== e[2:0]) begin
        errors++;
        $display("FAIL led t=%0t k=%0d got=%b exp=%b", $time, m_k, led, e[2:0]);
      end
      checks++;
      if (blink_phase !== e[3]) begin
        errors++;
        $display("FAIL blink_phase t=%0t k=%0d got=%b exp=%b", $time, m_k, blink_phase, e[3]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int mode, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_mode = 2'(mode);
    bus.wr_duty = 4'(duty);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_pwm(input int target);
    int guard;
    guard = 0;
    while (((m_k % PERIOD) != target) && (guard < 2 * PERIOD)) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_ch   = 2'd0;
    bus.wr_mode = 2'd0;
    bus.wr_duty = 4'd0;
    tick(3);
    rst = 1'b0;
    tick(64);

    wr(2, 1, 4);
    tick(48);

    wr(0, 1, 15);
    tick(32);
    wr(0, 1, 0);
    tick(32);
    wr(3, 1, 15);
    tick(32);

    wait_pwm(5);
    wr(2, 1, 8);
    tick(20);
    wait_pwm(15);
    wr(2, 1, 2);
    tick(32);

    wr(1, 2, 15);
    tick(80);

    wr(2, 3, 9);
    tick(100);
    tick($urandom_range(1, 20));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(80);

    for (int i = 0; i < 600; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_ch   = 2'($urandom_range(0, 3));
      bus.wr_mode = 2'($urandom_range(0, 3));
      bus.wr_duty = 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    bus.wr_en = 1'b0;
    rst       = 1'b0;
    tick(4);

    checks++;
    if (n_pops < 1000) begin
      errors++;
      $display("FAIL scoreboard_activity got=%0d exp>=%0d", n_pops, 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Multi-channel LED driver for the Pano G2 front-panel LEDs. It is the parametrised successor of the single-rate blinker. Each channel independently runs in one of four modes: OFF, ON, BLINK or BREATHE. Brightness comes from a shared PWM counter, and duty/mode updates are glitch-free because they are latched at PWM period boundaries. It sits at top level between board-control logic (or a future register bank) and the LED pins.

## Interface
- CLK_FREQ, 20000000: input clock frequency in Hz.
- BLINK_FREQ, 1: blink frequency and breathe-cycle rate, in Hz.
- NUM_CH, 3: number of LED channels (ch0 red, ch1 green, ch2 blue on G2).
- PWM_BITS, 8: PWM resolution; the period is 2^PWM_BITS cycles.
- ACTIVE_LOW, 3'b000: per-channel polarity mask, NUM_CH bits; a 1 means the pin is driven low when the LED is lit.

- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- wr_en  in  1  config write strobe, single cycle.
- wr_ch  in  max(1,$clog2(NUM_CH))  target channel; writes with wr_ch ≥ NUM_CH are ignored.
- wr_mode  in  2  mode encoding: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- wr_duty  in  PWM_BITS  brightness.
- led  out  NUM_CH  LED pins, registered, polarity per ACTIVE_LOW.
- blink_phase  out  1  current blink half-period (1 = lit half).

## Operation
- Derived constants:
  - BLINK_MAX = CLK_FREQ/BLINK_FREQ/2 − 1.
  - RAMP_MAX = max(1, CLK_FREQ/(BLINK_FREQ·2·(2^PWM_BITS−1))) − 1.
  - DUTY_FULL = 2^PWM_BITS − 1.
- pwm_cnt: PWM_BITS wide, free-running, increments every cycle, wraps DUTY_FULL→0. The "wrap" condition is pwm_cnt == DUTY_FULL.
- blink_cnt: counts 0..BLINK_MAX. On reaching BLINK_MAX it returns to 0 and toggles blink_phase.
- Breathe ramp:
  - ramp_div counts 0..RAMP_MAX; each time it hits RAMP_MAX, ramp steps ±1.
  - ramp reverses direction when it reaches DUTY_FULL (starts going down) and when it reaches 0 (starts going up).
  - One ramp is shared by all channels.
- Per channel:
  - A shadow {mode, duty} register is written by wr_en when wr_ch matches.
  - An active {mode, duty} register loads from the shadow on wrap.
  - If a write coincides with wrap, the written value goes straight to active (bypass); it is not lost or delayed a period.
- Effective duty: OFF → 0; ON → duty; BLINK → duty when blink_phase = 1, else 0; BREATHE → ramp (the duty register is ignored).
- lit = (eff_duty == DUTY_FULL) | (pwm_cnt < eff_duty). Consequences: duty 0 is never lit; DUTY_FULL is constantly lit.
- Output: led[i] <= lit_i ^ ACTIVE_LOW[i].

## Timing
- Reset values:
  - All counters 0; ramp 0 with direction up; blink_phase 0.
  - All shadow and active registers are OFF with duty 0.
  - led = ACTIVE_LOW (every channel at its inactive level).
- Reset mid-operation: the cycle after rst is sampled high, every register above holds its reset value. No partial PWM period survives.
- Write latency: a write at edge t reaches active at the next wrap edge. In the worst case that is 2^PWM_BITS cycles; in the bypass case it is edge t itself.
- Output latency: led lags pwm_cnt/eff_duty by one cycle. With duty d, led is lit during the cycles following pwm_cnt = 0..d−1.
- blink_phase toggles every BLINK_MAX+1 cycles. A BLINK channel change takes effect mid-PWM-period, with no resync.
- One full breathe cycle takes 2·DUTY_FULL·(RAMP_MAX+1) cycles.
- There is no backpressure: wr_en is accepted every cycle, and the last write before wrap wins.

## Structure
- Package led_pwm_pkg contains:
  - the led_mode_t typedef: LED_OFF = 0, LED_ON = 1, LED_BLINK = 2, LED_BREATHE = 3;
  - a derived-constant function for BLINK_MAX/RAMP_MAX.
- The top level owns pwm_cnt, blink_cnt/blink_phase, ramp_div/ramp and write decode.
- Sub-module led_pwm_channel is instantiated NUM_CH times via generate. It holds the shadow/active registers, the eff_duty mux, the compare and the polarity output flop. Its inputs are pwm_cnt, wrap, blink_phase, ramp, its write strobe and its ACTIVE_LOW bit.

## Test plan
Bench parameters: CLK_FREQ = 3000, BLINK_FREQ = 100, PWM_BITS = 4, NUM_CH = 3, ACTIVE_LOW = 3'b011. This gives BLINK_MAX = 14, RAMP_MAX = 0, DUTY_FULL = 15.
- Reset: rst high for 3 cycles → led = 3'b011 and blink_phase = 0. Then 64 cycles with no writes → led stays 3'b011, and blink_phase toggles every 15 cycles.
- ON: write ch2 mode 1, duty 4 → after the next wrap, led[2] is high for exactly 4 consecutive cycles in every 16-cycle period, one cycle after pwm_cnt = 0.
- Extremes: ch0 duty 15 ON → led[0] is constantly 0 (active-low, lit). Then ch0 duty 0 → led[0] is constantly 1 from the next period on. wr_ch = 3 → no channel changes.
- Shadow/bypass: ch2 at duty 4; write duty 8 at pwm_cnt = 5 → the remainder of that period still uses 4, and the next period is lit for 8 cycles. A write with duty 2 during the wrap cycle → the next period is lit for 2 cycles.
- BLINK: ch1 mode 2, duty 15 → led[1] = 0 exactly while blink_phase = 1 (lag of one cycle) and 1 otherwise.
- BREATHE plus mid-run reset: ch2 mode 3 → the per-period lit count follows ramp 0→15→0 with a 30-cycle ramp period. Assert rst at an arbitrary cycle → the next cycle satisfies the reset-values check, and the ramp restarts from 0.
